// File: rtl/data_memory_wait.sv
// Byte-addressable RV32 data memory with request/response handshake and WAIT_CYCLES wait states.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into errors.
module data_memory_wait #(
  parameter int    DEPTH_WORDS = 64,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
  localparam logic [1:0] S_FIRST  = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we_p0;
  logic [2:0]    r_f3_p0;
  logic [31:0]   r_addr_p0;
  logic [31:0]   r_wdata_p0;
  logic [31:0]   r_word_p1;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_range_err;
  logic          w_f3_err;
  logic          w_mis_err;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > 3'b010);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  assign req_ready   = (r_state == S_IDLE);
  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_idx       = r_addr_p0[AW+1:2];
  assign w_range_err = |(r_addr_p0 >> (AW + 2));
  assign w_f3_err    = f3_illegal(r_we_p0, r_f3_p0);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_mis_err   = ((r_f3_p0[1:0] == 2'b01) && r_addr_p0[0]) ||
                       ((r_f3_p0[1:0] == 2'b10) && (r_addr_p0[1:0] != 2'b00));
`else
  assign w_mis_err   = 1'b0;
`endif
  assign w_err       = w_range_err || w_f3_err || w_mis_err;
  assign w_be        = byte_en(r_f3_p0, r_addr_p0[1:0]);
  assign w_wlane     = lane_data(r_f3_p0, r_wdata_p0);

  // p0: request capture
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we_p0    <= req_we;
      r_f3_p0    <= req_funct3;
      r_addr_p0  <= req_addr;
      r_wdata_p0 <= req_wdata;
    end
  end

  // p1: array access; an abort forces IDLE before this edge so nothing is written
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS) begin
      r_word_p1 <= r_mem[w_idx];
      if (r_we_p0 && !w_err) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
        end
      end
    end
  end

  // p2: control and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state <= S_FIRST;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP: begin
          r_state   <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= w_err;
          rsp_rdata <= (w_err || r_we_p0) ? 32'd0 : load_ext(r_word_p1, r_f3_p0, r_addr_p0[1:0]);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_wait.sv
// Scoreboard bench for data_memory_wait: three instances with WAIT_CYCLES of 1, 0 and 4.
module tb_data_memory_wait;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_wait #(
      .DEPTH_WORDS (64),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 4)),
      .INIT_FILE   ("")
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] mdl [3][64];
  int          cyc   = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 4);
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    case (d)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference behaviour: masks and shifts over a word model of each instance
  task automatic model_req(input int d, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    logic        err;
    logic [5:0]  idx;
    logic [31:0] w, m;
    int          sh;
    idx = addr[7:2];
    err = ((addr >> 8) != 32'd0);
    if (we) err = err || !(f3 inside {3'd0, 3'd1, 3'd2});
    else    err = err || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) err = 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    e.rdata = 32'd0;
    e.err   = err;
    e.due   = 0;
    if (!err) begin
      w = mdl[d][idx];
      if (we) begin
        case (f3)
          3'd0:    begin sh = 8 * int'(addr[1:0]); m = 32'h0000_00ff << sh; end
          3'd1:    begin sh = 16 * int'(addr[1]);  m = 32'h0000_ffff << sh; end
          default: begin sh = 0;                   m = 32'hffff_ffff;       end
        endcase
        mdl[d][idx] = (w & ~m) | ((wdata << sh) & m);
      end else begin
        case (f3)
          3'd0, 3'd4: begin
            e.rdata = (w >> (8 * int'(addr[1:0]))) & 32'h0000_00ff;
            if (f3 == 3'd0 && e.rdata[7]) e.rdata = e.rdata | 32'hffff_ff00;
          end
          3'd1, 3'd5: begin
            e.rdata = (w >> (16 * int'(addr[1]))) & 32'h0000_ffff;
            if (f3 == 3'd1 && e.rdata[15]) e.rdata = e.rdata | 32'hffff_0000;
          end
          default: e.rdata = w;
        endcase
      end
    end
  endtask

  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit expect_rsp);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      chk_eq($sformatf("ready_timeout%0d", d), 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    if (expect_rsp) begin
      model_req(d, we, f3, addr, wdata, e);
      e.due = cyc + wc_of(d) + 3;
      qpush(d, e);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      if (rsp_valid[d]) begin
        if (qsize(d) == 0) begin
          chk_eq($sformatf("unexpected_rsp%0d", d), 32'(rsp_valid[d]), 32'd0);
        end else begin
          e = qfront(d);
          qpop(d);
          chk_eq($sformatf("rdata%0d", d), rsp_rdata[d], e.rdata);
          chk_eq($sformatf("err%0d", d), 32'(rsp_err[d]), 32'(e.err));
          chk_eq($sformatf("latency%0d", d), 32'(cyc), 32'(e.due));
        end
      end else if (qsize(d) != 0) begin
        e = qfront(d);
        if (cyc > e.due) begin
          chk_eq($sformatf("missing_rsp%0d", d), 32'(rsp_valid[d]), 32'd1);
          qpop(d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    exp_t       e;
    for (int d = 0; d < 3; d++) begin
      rst_n[d]      = 1'b0;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = 3'd0;
      req_addr[d]   = 32'd0;
      req_wdata[d]  = 32'd0;
      for (int i = 0; i < 64; i++) mdl[d][i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk_eq($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'd1);
      chk_eq($sformatf("rst_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk_eq($sformatf("rst_rdata%0d", d), rsp_rdata[d], 32'd0);
      chk_eq($sformatf("rst_err%0d", d), 32'(rsp_err[d]), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // Instance 0 (one wait state): word, sub-word, illegal and misaligned accesses
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1); drain(0);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b1, 3'b000, 32'h13, 32'h7F, 1'b1);       drain(0);
    do_req(0, 1'b1, 3'b001, 32'h10, 32'h8001, 1'b1);     drain(0);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b0, 3'b000, 32'h10, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b0, 3'b001, 32'h10, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b0, 3'b101, 32'h10, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b1, 3'b010, 32'h20, 32'hA5A55A5A, 1'b1); drain(0);
    do_req(0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);       drain(0);
    do_req(0, 1'b1, 3'b100, 32'h20, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1);        drain(0);
    do_req(0, 1'b0, 3'b001, 32'h11, 32'h0, 1'b1);        drain(0);
    chk_eq("word10_model", mdl[0][4], 32'h7FAD8001);

    // Instance 1 (no wait states): request held for six cycles
    pat = 6'b100100;
    @(negedge clk);
    req_we[1]     = 1'b1;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 32'h04;
    req_wdata[1]  = 32'h11112222;
    req_valid[1]  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk_eq($sformatf("ready_pattern[%0d]", i), 32'(req_ready[1]), 32'(pat[5-i]));
      if (req_ready[1]) begin
        model_req(1, 1'b1, 3'b010, 32'h04, 32'h11112222, e);
        e.due = cyc + 3;
        qpush(1, e);
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    drain(1);
    do_req(1, 1'b0, 3'b010, 32'h04, 32'h0, 1'b1); drain(1);

    // Instance 2 (four wait states): store aborted by reset in its second wait cycle
    do_req(2, 1'b1, 3'b010, 32'h08, 32'hCAFEF00D, 1'b1); drain(2);
    do_req(2, 1'b1, 3'b010, 32'h08, 32'h12345678, 1'b0);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk_eq("abort_valid", 32'(rsp_valid[2]), 32'd0);
    chk_eq("abort_ready", 32'(req_ready[2]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (12) @(negedge clk);
    do_req(2, 1'b0, 3'b010, 32'h08, 32'h0, 1'b1); drain(2);

    repeat (5) @(negedge clk);
    chk_eq("pending_at_end", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
